// File: rtl/act_pkg.sv
// Shared constants and helpers for the neuron activation stage.
package act_pkg;

  localparam int DEF_DATA_WIDTH       = 16;
  localparam int DEF_WEIGHT_INT_WIDTH = 4;
  localparam int DEF_SIG_SIZE         = 10;
  localparam int DEF_FRAC_WIDTH       = DEF_DATA_WIDTH - DEF_WEIGHT_INT_WIDTH;

  localparam string ACT_RELU         = "relu";
  localparam string ACT_SIGMOID_FULL = "sigmoid_full";
  localparam string ACT_SIGMOID_HALF = "sigmoid_half";
  localparam string ACT_IDENTITY     = "identity";

  // oor: sum lies outside the sigmoid table range; idx: signed table index x
  // (only the low sig_size bits are meaningful).
  typedef struct packed {
    logic        oor;
    logic [31:0] idx;
  } sig_idx_t;

  // The top int_w+1 bits of sum must all match the sign for x to be a faithful
  // view of sum; idx is the sig_size-bit slice just below the integer bits.
  function automatic sig_idx_t sig_index(input logic [63:0] sum_ext,
                                         input int sum_w,
                                         input int int_w,
                                         input int sig_size);
    sig_idx_t r;
    logic     top;
    r.oor = 1'b0;
    r.idx = '0;
    top   = sum_ext[sum_w-1];
    for (int i = 1; i <= int_w; i++) begin
      if (sum_ext[sum_w-1-i] != top) r.oor = 1'b1;
    end
    for (int i = 0; i < sig_size; i++) begin
      r.idx[i] = sum_ext[sum_w-int_w-sig_size+i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sigmoid_rom.sv
// Synchronous-read sigmoid table. HALF=0 holds T(v) for the full signed range
// in offset-binary order; HALF=1 holds T(v) for non-negative magnitudes only.
module sigmoid_rom
  import act_pkg::*;
#(
  parameter int    HALF             = 0,
  parameter int    SIG_SIZE         = DEF_SIG_SIZE,
  parameter int    DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int    WEIGHT_INT_WIDTH = DEF_WEIGHT_INT_WIDTH,
  parameter string INIT_FILE        = "sig_full.mem",
  localparam int   ADDR_W           = SIG_SIZE - HALF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     addr,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int DEPTH = 1 << ADDR_W;

  // INIT_FILE names the offline hex image of this table; the same T(v) formula
  // is evaluated here so the contents never drift from the image.
  if (INIT_FILE == "") begin : g_no_file
    $error("sigmoid_rom: INIT_FILE must name the table image");
  end

  // T(v) = min(round(sigmoid(v) * 2^(DATA_WIDTH-1)), 2^(DATA_WIDTH-1) - 1).
  // exp() is built from a short series on |v|/16 followed by four squarings.
  function automatic logic [DATA_WIDTH-1:0] t_entry(input int idx);
    real v, y, e, term, sig, q_r;
    int  r;
    v = $itor((HALF != 0) ? idx : idx - (1 << (SIG_SIZE-1)))
        / $itor(1 << (SIG_SIZE - WEIGHT_INT_WIDTH));
    y = ((v < 0.0) ? -v : v) / 16.0;
    e    = 1.0;
    term = 1.0;
    for (int k = 1; k < 20; k++) begin
      term = term * y / $itor(k);
      e    = e + term;
    end
    for (int k = 0; k < 4; k++) e = e * e;
    sig = (v < 0.0) ? 1.0 / (1.0 + e) : e / (1.0 + e);
    q_r = sig * $itor(1 << (DATA_WIDTH-1));
    r   = $rtoi(q_r + 0.5);
    if (r > (1 << (DATA_WIDTH-1)) - 1) r = (1 << (DATA_WIDTH-1)) - 1;
    return DATA_WIDTH'(r);
  endfunction

  logic [DATA_WIDTH-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_tab
    assign rom[i] = t_entry(i);
  end

  // Registered read; this register doubles as the activation output register.
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= rom[addr];
  end

endmodule

// File: rtl/neuron_activation_unit.sv
// Registered activation stage at the tail of each ELM neuron: one result per
// cycle, one cycle after the accumulator, function fixed at elaboration.
module neuron_activation_unit
  import act_pkg::*;
#(
  parameter int    DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int    WEIGHT_INT_WIDTH = DEF_WEIGHT_INT_WIDTH,
  parameter int    SIG_SIZE         = DEF_SIG_SIZE,
  parameter string ACT_TYPE         = ACT_SIGMOID_HALF,
  parameter string SIG_FULL_FILE    = "sig_full.mem",
  parameter string SIG_HALF_FILE    = "sig_half.mem"
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [2*DATA_WIDTH-1:0] sum,
  output logic [DATA_WIDTH-1:0]   out,
  output logic                    out_valid
);

  localparam int                    SUM_W      = 2*DATA_WIDTH;
  localparam int                    FRAC_WIDTH = DATA_WIDTH - WEIGHT_INT_WIDTH;
  localparam logic [DATA_WIDTH-1:0] SAT_POS    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] HALF_ONE   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Valid is a plain one-cycle delay; data is qualified by it downstream.
  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= in_valid;
  end

  if (ACT_TYPE == ACT_RELU) begin : g_relu
    logic [DATA_WIDTH-1:0] act_q;
    logic                  ovf;

    assign ovf = |sum[SUM_W-2 : SUM_W-1-WEIGHT_INT_WIDTH];

    // Clamp negatives to zero, saturate positives whose integer part overflows.
    always_ff @(posedge clk) begin
      if (rst)                               act_q <= '0;
      else if (sum[SUM_W-1] || (sum == '0))  act_q <= '0;
      else if (ovf)                          act_q <= SAT_POS;
      else act_q <= sum[SUM_W-1-WEIGHT_INT_WIDTH -: DATA_WIDTH];
    end

    assign out = act_q;

  end else if (ACT_TYPE == ACT_IDENTITY) begin : g_identity
    logic [DATA_WIDTH-1:0] act_q;
    logic                  id_unused;

    // Integer bits above the output range and sub-LSB fraction are dropped.
    assign id_unused = ^{sum[SUM_W-1 -: WEIGHT_INT_WIDTH], sum[FRAC_WIDTH-1:0]};

    // Straight truncating rescale, no saturation.
    always_ff @(posedge clk) begin
      if (rst) act_q <= '0;
      else     act_q <= sum[SUM_W-1-WEIGHT_INT_WIDTH -: DATA_WIDTH];
    end

    assign out = act_q;

  end else if ((ACT_TYPE == ACT_SIGMOID_FULL) || (ACT_TYPE == ACT_SIGMOID_HALF)) begin : g_sig
    sig_idx_t              si;
    logic [SIG_SIZE-1:0]   x;
    logic                  sig_unused;
    logic                  sat_q;
    logic                  neg_q;
    logic [DATA_WIDTH-1:0] rom_q;
    logic [DATA_WIDTH-1:0] tab_val;

    assign si         = sig_index(64'(sum), SUM_W, WEIGHT_INT_WIDTH, SIG_SIZE);
    assign x          = si.idx[SIG_SIZE-1:0];
    assign sig_unused = ^si.idx[31:SIG_SIZE];

    // Range flags travel alongside the ROM read so the output mux stays aligned.
    always_ff @(posedge clk) begin
      if (rst) begin
        sat_q <= 1'b0;
        neg_q <= 1'b0;
      end else begin
        sat_q <= si.oor;
        neg_q <= sum[SUM_W-1];
      end
    end

    if (ACT_TYPE == ACT_SIGMOID_FULL) begin : g_full
      logic [SIG_SIZE-1:0] addr;

      // Offset binary: flipping the sign bit adds 2^(SIG_SIZE-1).
      assign addr = {~x[SIG_SIZE-1], x[SIG_SIZE-2:0]};

      sigmoid_rom #(
        .HALF             (0),
        .SIG_SIZE         (SIG_SIZE),
        .DATA_WIDTH       (DATA_WIDTH),
        .WEIGHT_INT_WIDTH (WEIGHT_INT_WIDTH),
        .INIT_FILE        (SIG_FULL_FILE)
      ) u_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .q    (rom_q)
      );

      assign tab_val = rom_q;

    end else begin : g_half
      logic [SIG_SIZE-2:0] mag;
      logic                flip_q;

      // |x|, with the most-negative code clamped to the largest stored magnitude.
      always_comb begin
        mag = x[SIG_SIZE-2:0];
        if (x[SIG_SIZE-1]) begin
          if (x[SIG_SIZE-2:0] == '0) mag = '1;
          else                       mag = ~x[SIG_SIZE-2:0] + 1'b1;
        end
      end

      // Negative indices reuse the positive entry via sigmoid(-v) = 1 - sigmoid(v).
      always_ff @(posedge clk) begin
        if (rst) flip_q <= 1'b0;
        else     flip_q <= x[SIG_SIZE-1];
      end

      sigmoid_rom #(
        .HALF             (1),
        .SIG_SIZE         (SIG_SIZE),
        .DATA_WIDTH       (DATA_WIDTH),
        .WEIGHT_INT_WIDTH (WEIGHT_INT_WIDTH),
        .INIT_FILE        (SIG_HALF_FILE)
      ) u_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (mag),
        .q    (rom_q)
      );

      assign tab_val = flip_q ? (HALF_ONE - rom_q) : rom_q;
    end

    assign out = sat_q ? (neg_q ? '0 : SAT_POS) : tab_val;

  end else begin : g_bad_act
    $error("neuron_activation_unit: unknown ACT_TYPE %s", ACT_TYPE);
    assign out = '0;
  end

endmodule

// File: tb/tb_neuron_activation_unit.sv
// Bench for neuron_activation_unit: all four activation flavours side by side,
// driven with directed and random accumulators, checked against a real-valued model.
module tb_neuron_activation_unit;

  localparam longint RANGE = 64'sd1 <<< 27;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] sum;
  logic [15:0] out_relu, out_full, out_half, out_id;
  logic        ov_relu, ov_full, ov_half, ov_id;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  neuron_activation_unit #(.ACT_TYPE("relu")) u_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_relu), .out_valid(ov_relu));
  neuron_activation_unit #(.ACT_TYPE("sigmoid_full")) u_full (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_full), .out_valid(ov_full));
  neuron_activation_unit #(.ACT_TYPE("sigmoid_half")) u_half (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_half), .out_valid(ov_half));
  neuron_activation_unit #(.ACT_TYPE("identity")) u_id (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_id), .out_valid(ov_id));

  // ---- reference model: real-valued sigmoid and plain integer arithmetic ----
  function automatic int sig_t(input real v);
    real q;
    int  r;
    q = 32768.0 / (1.0 + $exp(-v));
    r = $rtoi(q + 0.5);
    if (r > 32767) r = 32767;
    return r;
  endfunction

  function automatic int m_full(input logic [31:0] s);
    longint sv, x;
    sv = longint'($signed(s));
    if (sv < -RANGE)  return 0;
    if (sv >= RANGE)  return 32767;
    x = sv >>> 18;
    return sig_t(real'(x) / 64.0);
  endfunction

  function automatic int m_half(input logic [31:0] s);
    longint sv, x, m;
    sv = longint'($signed(s));
    if (sv < -RANGE)  return 0;
    if (sv >= RANGE)  return 32767;
    x = sv >>> 18;
    if (x >= 0) return sig_t(real'(x) / 64.0);
    m = -x;
    if (m > 511) m = 511;
    return 32768 - sig_t(real'(m) / 64.0);
  endfunction

  function automatic int m_relu(input logic [31:0] s);
    longint sv, q;
    sv = longint'($signed(s));
    if (sv <= 0) return 0;
    q = sv >>> 12;
    return (q > 32767) ? 32767 : int'(q);
  endfunction

  function automatic int m_id(input logic [31:0] s);
    longint sv;
    sv = longint'($signed(s));
    return int'((sv >>> 12) & 64'hFFFF);
  endfunction

  // ---- checking ----
  task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
    int d;
    n_chk++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] s);
    chk({tag, "/relu"}, int'(out_relu), m_relu(s));
    chk({tag, "/full"}, int'(out_full), m_full(s));
    chk({tag, "/half"}, int'(out_half), m_half(s));
    chk({tag, "/half_vs_full"}, int'(out_half), m_full(s), 1);
    chk({tag, "/ident"}, int'(out_id), m_id(s));
  endtask

  // Called at a negedge: apply s with in_valid high, then check one cycle later.
  task automatic run_vec(input string tag, input logic [31:0] s);
    sum      = s;
    in_valid = 1'b1;
    @(negedge clk);
    chk({tag, "/valid"}, int'(ov_full), 1);
    chk_all(tag, s);
  endtask

  function automatic logic [31:0] gen_sum();
    logic [31:0] r;
    logic [31:0] edges [7];
    edges = '{32'h07FF_FFFF, 32'h0800_0000, 32'hF800_0000, 32'hF7FF_FFFF,
              32'h0000_0000, 32'h0000_1000, 32'hFFFF_F000};
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return r;
      1:       return {{5{r[26]}}, r[26:0]};
      2:       return {{17{r[14]}}, r[14:0]};
      default: return edges[$urandom_range(0, 6)];
    endcase
  endfunction

  initial begin
    logic [31:0] s;

    // reset dominates in_valid
    rst      = 1'b1;
    in_valid = 1'b1;
    sum      = 32'h0123_4567;
    repeat (3) @(negedge clk);
    chk("rst/out_relu", int'(out_relu), 0);
    chk("rst/out_full", int'(out_full), 0);
    chk("rst/out_half", int'(out_half), 0);
    chk("rst/out_id",   int'(out_id),   0);
    chk("rst/ov", int'({ov_relu, ov_full, ov_half, ov_id}), 0);

    // single-cycle valid pulse
    rst      = 1'b0;
    in_valid = 1'b1;
    sum      = 32'h0;
    @(negedge clk);
    chk("pulse/ov_hi", int'({ov_relu, ov_full, ov_half, ov_id}), 15);
    chk_all("pulse", 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pulse/ov_lo", int'({ov_relu, ov_full, ov_half, ov_id}), 0);

    // sigmoid mid-range (named values accepted within one LSB)
    run_vec("zero", 32'h0000_0000);
    chk("zero/full_4000", int'(out_full), 16'h4000);
    chk("zero/half_4000", int'(out_half), 16'h4000);
    chk("zero/relu", int'(out_relu), 0);
    run_vec("p1", 32'h0100_0000);
    chk("p1/full", int'(out_full), 23956, 1);
    chk("p1/half", int'(out_half), 23956, 1);
    run_vec("m1", 32'hFF00_0000);
    chk("m1/full", int'(out_full), 8812, 1);
    chk("m1/half", int'(out_half), 8812, 1);

    // sigmoid saturation and the most-negative index
    run_vec("satp", 32'h4000_0000);
    chk("satp/full", int'(out_full), 16'h7FFF);
    chk("satp/half", int'(out_half), 16'h7FFF);
    run_vec("satn", 32'hC000_0000);
    chk("satn/full", int'(out_full), 0);
    chk("satn/half", int'(out_half), 0);
    run_vec("m8", 32'hF800_0000);
    chk("m8/full", int'(out_full), 11);
    chk("m8/half", int'(out_half), 11, 1);

    // relu corners
    run_vec("r25", 32'h0280_0000);
    chk("r25/relu", int'(out_relu), 16'h2800);
    run_vec("rneg", 32'hFD80_0000);
    chk("rneg/relu", int'(out_relu), 0);
    run_vec("rovf", 32'h0800_0000);
    chk("rovf/relu", int'(out_relu), 16'h7FFF);

    // back-to-back random stream, in_valid held high
    for (int i = 0; i < 400; i++) begin
      s = gen_sum();
      run_vec("rnd", s);
    end

    in_valid = 1'b0;
    @(negedge clk);
    chk("tail/ov_lo", int'({ov_relu, ov_full, ov_half, ov_id}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
